// File: rtl/upsample_pix_stream_pkg.sv
// Shared definitions for the nearest-neighbour pixel upsampler.
// Holds the replication/size helpers, the coordinate width and the row-state encoding.
package upsample_pix_stream_pkg;

  localparam int coordW = 16;

  // FILL rows consume new low-resolution pixels; REPEAT rows replay the line buffer.
  typedef enum logic {
    FILL   = 1'b0,
    REPEAT = 1'b1
  } fillState_t;

  function automatic int repFactor(input int downS);
    return 1 << downS;
  endfunction

  function automatic int lowWidth(input int frameW, input int downS);
    return frameW >> downS;
  endfunction

  function automatic int lowHeight(input int frameH, input int downS);
    return frameH >> downS;
  endfunction

  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/upsample_pix_stream_line_buffer.sv
// One low-resolution row of pixels, written while a FILL row streams in
// and read back combinationally while the REPEAT rows replay it.
module pix_line_buffer
  import upsample_pix_stream_pkg::*;
#(
  parameter int dataW = 8,
  parameter int depth = 100
) (
  input  logic                        pixClk,
  input  logic                        wrEn,
  input  logic [addrWidth(depth)-1:0] wrAddr,
  input  logic [dataW-1:0]            wrData,
  input  logic [addrWidth(depth)-1:0] rdAddr,
  output logic [dataW-1:0]            rdData
);

  logic [dataW-1:0] mem [depth];

  // Store the accepted input pixel at its low-resolution column
  always_ff @(posedge pixClk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/upsample_pix_stream.sv
// Nearest-neighbour upsampler: each low-resolution pixel is repeated 2^downS
// times across a row and each buffered row is replayed 2^downS times down the
// frame, with full-resolution coordinates registered alongside every pixel.
module upsample_pix_stream
  import upsample_pix_stream_pkg::*;
#(
  parameter int dataW  = 8,
  parameter int frameW = 200,
  parameter int frameH = 200,
  parameter int downS  = 1
) (
  input  logic              pixClk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [dataW-1:0]  in_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [dataW-1:0]  out_pix,
  output logic [coordW-1:0] out_x,
  output logic [coordW-1:0] out_y,
  output logic              out_last
);

  localparam int repN  = repFactor(downS);
  localparam int lowW  = lowWidth(frameW, downS);
  localparam int lowH  = lowHeight(frameH, downS);
  localparam int addrW = addrWidth(lowW);

  localparam logic [coordW-1:0] sxMax = coordW'(repN - 1);
  localparam logic [coordW-1:0] lxMax = coordW'(lowW - 1);
  localparam logic [coordW-1:0] lyMax = coordW'(lowH - 1);
  localparam logic [coordW-1:0] lastX = coordW'(frameW - 1);
  localparam logic [coordW-1:0] lastY = coordW'(frameH - 1);

  fillState_t        state;
  logic [coordW-1:0] sx;
  logic [coordW-1:0] lx;
  logic [coordW-1:0] sy;
  logic [coordW-1:0] ly;
  logic [dataW-1:0]  holdPix;
  logic [dataW-1:0]  bufRdData;
  logic [dataW-1:0]  srcPix;
  logic [coordW-1:0] curX;
  logic [coordW-1:0] curY;
  logic              srcIsInput;
  logic              srcAvail;
  logic              canLoad;
  logic              loadOut;
  logic              acceptIn;

  // Only the first replica of a FILL row needs a fresh input pixel; every
  // other output is sourced internally and is always available.
  assign srcIsInput = (state == FILL) && (sx == '0);
  assign canLoad    = !out_valid || out_ready;
  assign srcAvail   = !srcIsInput || in_valid;
  assign loadOut    = canLoad && srcAvail;
  assign in_ready   = rst_n && srcIsInput && canLoad;
  assign acceptIn   = in_ready && in_valid;

  assign curX = (lx << downS) + sx;
  assign curY = (ly << downS) + sy;

  pix_line_buffer #(
    .dataW (dataW),
    .depth (lowW)
  ) lineBuf (
    .pixClk (pixClk),
    .wrEn   (acceptIn),
    .wrAddr (lx[addrW-1:0]),
    .wrData (in_pix),
    .rdAddr (lx[addrW-1:0]),
    .rdData (bufRdData)
  );

  // Choose the pixel for the next output: live input, held replica or buffered row
  always_comb begin
    srcPix = in_pix;
    if (!srcIsInput) begin
      srcPix = (state == FILL) ? holdPix : bufRdData;
    end
  end

  // Output register, held pixel, raster counters and row state advance together on each load
  always_ff @(posedge pixClk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      sx        <= '0;
      lx        <= '0;
      sy        <= '0;
      ly        <= '0;
      holdPix   <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else begin
      if (acceptIn) begin
        holdPix <= in_pix;
      end
      if (loadOut) begin
        out_valid <= 1'b1;
        out_pix   <= srcPix;
        out_x     <= curX;
        out_y     <= curY;
        out_last  <= (curX == lastX) && (curY == lastY);
        if (sx == sxMax) begin
          sx <= '0;
          if (lx == lxMax) begin
            lx <= '0;
            if (sy == syMaxOf()) begin
              sy    <= '0;
              state <= FILL;
              ly    <= (ly == lyMax) ? '0 : ly + 1'b1;
            end else begin
              sy    <= sy + 1'b1;
              state <= REPEAT;
            end
          end else begin
            lx <= lx + 1'b1;
          end
        end else begin
          sx <= sx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Vertical replica count matches the horizontal one
  function automatic logic [coordW-1:0] syMaxOf();
    return sxMax;
  endfunction

endmodule

// File: tb/tb_upsample_pix_stream.sv
// Directed bench for upsample_pix_stream: an 8x4 frame with 2x replication
// and a 4x2 pass-through instance, both driven from expected-value tables.
module tb_upsample_pix_stream;

  typedef struct {
    logic [7:0]  pix;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } outVec_t;

  logic        pixClk;
  logic        rst_n;

  logic        aInValid, aInReady, aOutValid, aOutReady, aOutLast;
  logic [7:0]  aInPix, aOutPix;
  logic [15:0] aOutX, aOutY;

  logic        bInValid, bInReady, bOutValid, bOutReady, bOutLast;
  logic [7:0]  bInPix, bOutPix;
  logic [15:0] bOutX, bOutY;

  int      errors;
  int      checks;
  outVec_t expQ[$];
  int      pixQ[$];
  int      transfers;
  int      gapCycles;
  int      acceptedCnt;
  int      bubbleIdx;
  int      bubbleLeft;
  int      stallLeft;
  bit      seenValid;
  bit      stallArmed;
  outVec_t bTbl[8];

  upsample_pix_stream #(
    .dataW (8), .frameW (8), .frameH (4), .downS (1)
  ) dutA (
    .pixClk    (pixClk),
    .rst_n     (rst_n),
    .in_valid  (aInValid),
    .in_ready  (aInReady),
    .in_pix    (aInPix),
    .out_valid (aOutValid),
    .out_ready (aOutReady),
    .out_pix   (aOutPix),
    .out_x     (aOutX),
    .out_y     (aOutY),
    .out_last  (aOutLast)
  );

  upsample_pix_stream #(
    .dataW (8), .frameW (4), .frameH (2), .downS (0)
  ) dutB (
    .pixClk    (pixClk),
    .rst_n     (rst_n),
    .in_valid  (bInValid),
    .in_ready  (bInReady),
    .in_pix    (bInPix),
    .out_valid (bOutValid),
    .out_ready (bOutReady),
    .out_pix   (bOutPix),
    .out_x     (bOutX),
    .out_y     (bOutY),
    .out_last  (bOutLast)
  );

  // Free-running pixel clock
  initial pixClk = 1'b0;
  always #5 pixClk = ~pixClk;

  // Hard stop in case a loop bound is ever missed
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic resetScenario();
    transfers   = 0;
    gapCycles   = 0;
    acceptedCnt = 0;
    bubbleIdx   = -1;
    bubbleLeft  = 0;
    stallLeft   = 0;
    seenValid   = 1'b0;
    stallArmed  = 1'b0;
  endtask

  // Drive the upstream producer and downstream consumer of instance A for the coming cycle
  task automatic applyStimulus();
    if (stallArmed && aOutValid && aOutX == 16'd3 && aOutY == 16'd1) begin
      stallArmed = 1'b0;
      stallLeft  = 3;
    end
    if (stallLeft > 0) begin
      aOutReady = 1'b0;
      stallLeft--;
    end else begin
      aOutReady = 1'b1;
    end
    if (acceptedCnt == bubbleIdx && bubbleLeft > 0) begin
      aInValid = 1'b0;
      bubbleLeft--;
    end else begin
      aInValid = (pixQ.size() > 0);
    end
    aInPix = (pixQ.size() > 0) ? 8'(pixQ[0]) : 8'd0;
  endtask

  task automatic queueFrameA(input int base);
    outVec_t e;
    for (int i = 0; i < 8; i++) pixQ.push_back(base + i);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        e.pix  = 8'(base + (y / 2) * 4 + x / 2);
        e.x    = 16'(x);
        e.y    = 16'(y);
        e.last = (x == 7) && (y == 3);
        expQ.push_back(e);
      end
    end
  endtask

  // One clock of instance A: compare at the falling edge, redrive just after the rising edge
  task automatic stepA();
    outVec_t e;
    bit accepted;
    @(negedge pixClk);
    accepted = aInValid && aInReady;
    if (aOutValid && aOutReady) begin
      transfers++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL A extra output: actual=(%0d,%0d) required=none", aOutX, aOutY);
      end else begin
        e = expQ.pop_front();
        checkOutput($sformatf("A pix #%0d", transfers), int'(aOutPix), int'(e.pix));
        checkOutput($sformatf("A x #%0d", transfers), int'(aOutX), int'(e.x));
        checkOutput($sformatf("A y #%0d", transfers), int'(aOutY), int'(e.y));
        checkOutput($sformatf("A last #%0d", transfers), int'(aOutLast), int'(e.last));
      end
    end
    if (!aOutReady) begin
      checkOutput("stall out_valid", int'(aOutValid), 1);
      checkOutput("stall pix", int'(aOutPix), 1);
      checkOutput("stall x", int'(aOutX), 3);
      checkOutput("stall y", int'(aOutY), 1);
      checkOutput("stall in_ready", int'(aInReady), 0);
    end
    if (seenValid && !aOutValid && expQ.size() > 0) gapCycles++;
    if (aOutValid) seenValid = 1'b1;
    @(posedge pixClk);
    #1;
    if (accepted) begin
      pixQ.delete(0);
      acceptedCnt++;
    end
    applyStimulus();
  endtask

  task automatic runA(input string name, input int budget);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < budget) begin
      stepA();
      n++;
    end
    checkOutput({name, " outputs left after budget"}, expQ.size(), 0);
  endtask

  initial begin
    outVec_t e;
    int n;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    aInValid  = 1'b0;
    aInPix    = 8'd0;
    aOutReady = 1'b1;
    bInValid  = 1'b0;
    bInPix    = 8'd0;
    bOutReady = 1'b1;
    resetScenario();

    // Reset state
    #12;
    checkOutput("reset out_valid", int'(aOutValid), 0);
    checkOutput("reset out_pix", int'(aOutPix), 0);
    checkOutput("reset out_x", int'(aOutX), 0);
    checkOutput("reset out_y", int'(aOutY), 0);
    checkOutput("reset out_last", int'(aOutLast), 0);
    checkOutput("reset in_ready", int'(aInReady), 0);
    @(negedge pixClk);
    rst_n = 1'b1;
    @(posedge pixClk);
    #1;
    checkOutput("release in_ready", int'(aInReady), 1);
    checkOutput("release out_valid", int'(aOutValid), 0);

    // Two frames back to back with continuous input and no backpressure
    $display("[TB] back-to-back frames");
    resetScenario();
    queueFrameA(0);
    queueFrameA(100);
    applyStimulus();
    runA("back-to-back", 200);
    checkOutput("back-to-back transfers", transfers, 64);
    checkOutput("back-to-back gap cycles", gapCycles, 0);

    // Consumer stalls for three cycles while (3,1) is presented
    $display("[TB] backpressure at (3,1)");
    resetScenario();
    stallArmed = 1'b1;
    queueFrameA(0);
    applyStimulus();
    runA("stall", 100);
    checkOutput("stall transfers", transfers, 32);
    checkOutput("stall taken", int'(stallArmed), 0);

    // Producer withholds low-resolution pixel 2 for two cycles
    $display("[TB] input bubble before pixel 2");
    resetScenario();
    bubbleIdx  = 2;
    bubbleLeft = 2;
    queueFrameA(0);
    applyStimulus();
    runA("bubble", 100);
    checkOutput("bubble transfers", transfers, 32);
    checkOutput("bubble gap cycles", gapCycles, 1);

    // Reset pulse after five outputs aborts the frame
    $display("[TB] mid-frame reset");
    resetScenario();
    queueFrameA(0);
    applyStimulus();
    n = 0;
    while (transfers < 5 && n < 50) begin
      stepA();
      n++;
    end
    checkOutput("pre-reset transfers", transfers, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", int'(aOutValid), 0);
    checkOutput("mid-reset out_pix", int'(aOutPix), 0);
    checkOutput("mid-reset out_x", int'(aOutX), 0);
    checkOutput("mid-reset out_y", int'(aOutY), 0);
    checkOutput("mid-reset out_last", int'(aOutLast), 0);
    checkOutput("mid-reset in_ready", int'(aInReady), 0);
    aInValid = 1'b0;
    expQ.delete();
    pixQ.delete();
    @(negedge pixClk);
    rst_n = 1'b1;
    @(posedge pixClk);
    #1;
    resetScenario();
    pixQ.push_back(99);
    e.pix  = 8'd99;
    e.x    = 16'd0;
    e.y    = 16'd0;
    e.last = 1'b0;
    expQ.push_back(e);
    applyStimulus();
    runA("post-reset", 20);

    // Pass-through instance: one output per accepted input, one cycle later
    $display("[TB] downS=0 pass-through");
    for (int i = 0; i < 8; i++) begin
      bTbl[i].pix  = 8'(10 + i);
      bTbl[i].x    = 16'(i % 4);
      bTbl[i].y    = 16'(i / 4);
      bTbl[i].last = (i == 7);
    end
    @(posedge pixClk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bInValid = 1'b1;
      bInPix   = bTbl[i].pix;
      @(negedge pixClk);
      checkOutput($sformatf("B in_ready #%0d", i), int'(bInReady), 1);
      @(posedge pixClk);
      #1;
      bInValid = 1'b0;
      checkOutput($sformatf("B out_valid #%0d", i), int'(bOutValid), 1);
      checkOutput($sformatf("B pix #%0d", i), int'(bOutPix), int'(bTbl[i].pix));
      checkOutput($sformatf("B x #%0d", i), int'(bOutX), int'(bTbl[i].x));
      checkOutput($sformatf("B y #%0d", i), int'(bOutY), int'(bTbl[i].y));
      checkOutput($sformatf("B last #%0d", i), int'(bOutLast), int'(bTbl[i].last));
    end
    @(posedge pixClk);
    #1;
    checkOutput("B drained out_valid", int'(bOutValid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
